// File: rtl/song_sequencer_if.sv
// Song ROM read port plus note-player handshake, as seen by the sequencer.
interface song_sequencer_if;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        done_with_note;
  logic        play_enable;

  // Sequencer side
  modport master (
    output rom_addr,
    output note_to_load,
    output duration_to_load,
    output load_new_note,
    output play_enable,
    input  rom_data,
    input  done_with_note
  );

  // ROM / note-player side
  modport slave (
    input  rom_addr,
    input  note_to_load,
    input  duration_to_load,
    input  load_new_note,
    input  play_enable,
    output rom_data,
    output done_with_note
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM one note at a time, hands each note to
// the note player with a one-cycle strobe and waits for it to finish.
module song_sequencer (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    play_pause_i,
  input  logic                    next_song_i,
  song_sequencer_if.master        seq_io,
  output logic [1:0]              current_song_o,
  output logic                    song_done_o
);

  localparam logic [2:0] StFetch = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StPlay  = 3'd3;
  localparam logic [2:0] StEnd   = 3'd4;

  logic [2:0] state_q, state_d;
  logic       playing_q, playing_d;
  logic [1:0] song_q, song_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] note_q, note_d;
  logic [5:0] dur_q, dur_d;
  logic       end_marker;

  // A zero duration marks the end of a song.
  assign end_marker = (seq_io.rom_data[5:0] == 6'd0);

  // Next-state logic; next_song overrides whatever the FSM would do.
  always_comb begin
    state_d   = state_q;
    playing_d = playing_q ^ play_pause_i;
    song_d    = song_q;
    idx_d     = idx_q;
    note_d    = note_q;
    dur_d     = dur_q;
    case (state_q)
      StFetch: begin
        if (playing_q) state_d = StWait;
      end
      StWait: begin
        if (playing_q) begin
          if (end_marker) begin
            state_d = StEnd;
          end else begin
            state_d = StLoad;
            note_d  = seq_io.rom_data[11:6];
            dur_d   = seq_io.rom_data[5:0];
          end
        end
      end
      StLoad: begin
        if (playing_q) state_d = StPlay;
      end
      StPlay: begin
        // While paused the note player is frozen, so done is not honoured.
        if (playing_q && seq_io.done_with_note) begin
          if (idx_q == 5'd31) begin
            state_d = StEnd;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      StEnd: begin
        song_d    = song_q + 2'd1;
        idx_d     = 5'd0;
        playing_d = 1'b0;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (next_song_i) begin
      // Single increment even in StEnd; playing keeps StEnd's clear if any.
      song_d  = song_q + 2'd1;
      idx_d   = 5'd0;
      state_d = StFetch;
      note_d  = note_q;
      dur_d   = dur_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StFetch;
      playing_q <= 1'b0;
      song_q    <= 2'd0;
      idx_q     <= 5'd0;
      note_q    <= 6'd0;
      dur_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      playing_q <= playing_d;
      song_q    <= song_d;
      idx_q     <= idx_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
    end
  end

  // Output decode.
  always_comb begin
    seq_io.rom_addr         = {song_q, idx_q};
    seq_io.note_to_load     = note_q;
    seq_io.duration_to_load = dur_q;
    seq_io.play_enable      = playing_q;
    seq_io.load_new_note    = (state_q == StLoad) && playing_q && !next_song_i && !reset_i;
    current_song_o          = song_q;
    song_done_o             = (state_q == StEnd);
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Controller that sequences the note player through songs stored in a synchronous song ROM. It fetches one note/duration word at a time, hands it to the note player with a single-cycle load strobe, and waits for the note player's done indication before fetching the next note. It owns the play/pause state and the current song number, and drives the note player's play enable. It sits between the user-input debouncers, the song ROM and the note player in the music player top level.

## Interface
- No parameters. Fixed geometry: 4 songs × 32 notes per song; 12-bit ROM word {note[11:6], duration[5:0]}.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- play_pause  in  1  one-cycle pulse; toggles playing
- next_song  in  1  one-cycle pulse; advance to next song
- rom_addr  out  7  {current_song[1:0], note_index[4:0]}
- rom_data  in  12  song ROM output, valid 1 cycle after rom_addr
- note_to_load  out  6  registered note to note player
- duration_to_load  out  6  registered duration to note player
- load_new_note  out  1  one-cycle load strobe to note player
- done_with_note  in  1  note player finished current note
- play_enable  out  1  equals playing
- current_song  out  2  song number
- song_done  out  1  one-cycle pulse at end of song

## Operation
- States: FETCH, WAIT, LOAD, PLAY, END.
- rom_addr is combinational from current_song and note_index and is always driven.
- playing flag: toggles on play_pause. play_enable = playing.
- FETCH → WAIT: only when playing.
- WAIT → LOAD: only when playing. Latch rom_data into note_to_load/duration_to_load on this transition.
- WAIT → END instead, if rom_data[5:0] == 0. Duration 0 is the end-of-song marker; note_to_load and duration_to_load are left unchanged.
- LOAD → PLAY: only when playing. load_new_note = (state == LOAD) && playing.
- PLAY: on done_with_note, advance:
  - note_index == 31 → go to END (no increment).
  - Otherwise → note_index+1, go to FETCH.
- PLAY while paused: hold. The note player freezes its own countdown.
- done_with_note is ignored in every state except PLAY.
- END (one cycle, unconditional):
  - song_done = 1
  - current_song+1, wrapping 3 → 0
  - note_index = 0, playing = 0
  - go to FETCH
- next_song (any state, takes priority over FSM transitions):
  - current_song+1 (wrap)
  - note_index = 0, state = FETCH
  - playing unchanged; load_new_note low that cycle
- next_song in the END cycle: exactly one song increment. song_done still pulses. playing is cleared.
- play_pause and next_song in the same cycle: both take effect.
- play_pause in the END cycle: END's clear wins, so playing = 0.

## Timing
- Reset values:
  - state = FETCH, playing = 0, current_song = 0, note_index = 0
  - note_to_load = 0, duration_to_load = 0
  - load_new_note = 0, song_done = 0, play_enable = 0
- Start latency: play_pause at cycle t (paused in FETCH) → playing = 1 at t+1, WAIT at t+2, load_new_note high at t+3.
- Note-to-note gap: done_with_note at cycle t → FETCH at t+1, WAIT t+2, LOAD (load_new_note high) t+3.
- note_to_load/duration_to_load are stable from the LOAD cycle until the next WAIT→LOAD latch.
- load_new_note and song_done are never high for more than one consecutive cycle.
- Pause in FETCH/WAIT holds the state. rom_addr does not change, so rom_data stays valid.
- Reset mid-operation: all state returns to reset values on the next edge. No load strobe is issued on the reset cycle.

## Test plan
- Reset, then play_pause pulse; ROM word (song 0, idx 0) = {6'd20, 6'd12} → load_new_note high exactly 3 cycles after the pulse, with note_to_load = 20 and duration_to_load = 12; play_enable = 1.
- Model done_with_note after each note; song 0 idx 0..2 loaded, idx 3 duration 0 → three load strobes with matching values, then song_done pulse, current_song = 1, play_enable = 0, no fourth strobe.
- Song with all 32 durations nonzero → 32 strobes; done at idx 31 → END, current_song advances, note_index = 0.
- Pause in WAIT for 10 cycles, then resume → no load_new_note while paused; strobe 1 cycle after resume with correct ROM data. Pause in PLAY → done_with_note ignored until playing.
- next_song during PLAY of song 3 → current_song = 0, note_index = 0, playing unchanged, next strobe loads song 0 idx 0 three cycles later; stale done_with_note during FETCH is ignored.
- Assert reset while in LOAD, and separately next_song in the END cycle → all outputs at reset values / single song increment (1 → 2 only).
